// File: rtl/memory_pkg.sv
// Shared constants and types for the memory_pipe slice.
//   MEM_READ_LATENCY_MIN/MAX : legal READ_LATENCY range
//   MEM_BYTE_WIDTH           : bits covered by one byte-enable
//   mem_rsp_t                : response word {rdata, err} at the default width
package memory_pkg;

  localparam int unsigned MEM_READ_LATENCY_MIN = 1;
  localparam int unsigned MEM_READ_LATENCY_MAX = 4;
  localparam int unsigned MEM_BYTE_WIDTH       = 8;
  localparam int unsigned MEM_RSP_DATA_WIDTH   = 16;

  typedef struct packed {
    logic [MEM_RSP_DATA_WIDTH-1:0] rdata;
    logic                          err;
  } mem_rsp_t;

endpackage

// File: rtl/memory_pipe_if.sv
// Request/response channel of memory_pipe.
//   req_*     : valid/ready request (write when req_we=1, else read)
//   rsp_*     : valid/ready read response with out-of-range flag
//   master    : requester side (load/store unit, fetch)
//   slave     : memory side
interface memory_pipe_if
  import memory_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 16
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / MEM_BYTE_WIDTH;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [BE_WIDTH-1:0]   req_be;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mem_rsp_fifo.sv
// Synchronous first-word-fall-through FIFO for read responses.
//   clk, rst_n : clock, async active-low reset (pointers/count only)
//   push, push_data : write an entry
//   pop        : drop the head entry
//   empty      : no entries stored
//   head       : current head entry (valid when !empty)
// Overflow/underflow protection is the caller's job (credit scheme).
module mem_rsp_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) store[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign empty = (count == '0);
  assign head  = store[rd_ptr];

endmodule

// File: rtl/memory_pipe.sv
// Single-port synchronous RAM with byte enables, valid/ready request channel,
// configurable registered read latency and a backpressure response buffer.
//   clk   : clock, rising edge
//   rst_n : async active-low reset (control state only; array not reset)
//   bus   : memory_pipe_if slave (req_* in, rsp_* out)
// A credit counter (in-flight reads + buffered responses) gates req_ready so
// the response FIFO can never overflow and the read pipeline never stalls.
module memory_pipe
  import memory_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 11,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned DEPTH        = 2**ADDR_WIDTH,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned RSP_DEPTH    = 2,
  parameter int unsigned BE_WIDTH     = DATA_WIDTH / MEM_BYTE_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  memory_pipe_if.slave  bus
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW    = $clog2(RSP_DEPTH + 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
  } rsp_t;

  if ((DATA_WIDTH % MEM_BYTE_WIDTH) != 0 || DATA_WIDTH == 0 ||
      BE_WIDTH != DATA_WIDTH / MEM_BYTE_WIDTH ||
      DEPTH < 1 || DEPTH > 2**ADDR_WIDTH ||
      READ_LATENCY < MEM_READ_LATENCY_MIN || READ_LATENCY > MEM_READ_LATENCY_MAX ||
      RSP_DEPTH < 1) begin : g_bad_params
    $error("memory_pipe: illegal parameter combination");
  end

  logic                  run_q;
  logic [CW-1:0]         credits;
  logic                  req_ready;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  in_range;
  logic [IDX_W-1:0]      idx;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  rsp_t                  pipe_rsp [READ_LATENCY];
  logic [READ_LATENCY-1:0] pipe_vld;
  logic                  last_vld;
  rsp_t                  last_rsp;

  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;
  rsp_t                  fifo_head;
  rsp_t                  out_rsp;
  logic                  rsp_valid;
  logic                  rsp_hs;

  // Ready depends only on registered state; run_q holds it low until the
  // first edge after reset release.
  assign req_ready = run_q && (credits < CW'(RSP_DEPTH));
  assign rd_acc    = bus.req_valid && req_ready && !bus.req_we;
  assign wr_acc    = bus.req_valid && req_ready &&  bus.req_we;
  assign in_range  = {1'b0, bus.req_addr} < (ADDR_WIDTH + 1)'(DEPTH);
  assign idx       = bus.req_addr[IDX_W-1:0];

  // Storage and read-data pipeline: no reset, so the array maps to block RAM.
  always_ff @(posedge clk) begin
    if (wr_acc && in_range) begin
      for (int unsigned b = 0; b < BE_WIDTH; b++) begin
        if (bus.req_be[b])
          mem[idx][b*MEM_BYTE_WIDTH +: MEM_BYTE_WIDTH] <= bus.req_wdata[b*MEM_BYTE_WIDTH +: MEM_BYTE_WIDTH];
      end
    end
    if (rd_acc) begin
      pipe_rsp[0].rdata <= in_range ? mem[idx] : '0;
      pipe_rsp[0].err   <= !in_range;
    end
    for (int unsigned i = 1; i < READ_LATENCY; i++)
      pipe_rsp[i] <= pipe_rsp[i-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q    <= 1'b0;
      credits  <= '0;
      pipe_vld <= '0;
    end else begin
      run_q       <= 1'b1;
      pipe_vld[0] <= rd_acc;
      for (int unsigned i = 1; i < READ_LATENCY; i++)
        pipe_vld[i] <= pipe_vld[i-1];
      case ({rd_acc, rsp_hs})
        2'b10:   credits <= credits + CW'(1);
        2'b01:   credits <= credits - CW'(1);
        default: credits <= credits;
      endcase
    end
  end

  assign last_vld = pipe_vld[READ_LATENCY-1];
  assign last_rsp = pipe_rsp[READ_LATENCY-1];

  // The last pipeline register doubles as the fall-through head when the FIFO
  // is empty; an unconsumed result moves into the FIFO on the next edge, so
  // the presented word is unchanged under backpressure.
  assign rsp_valid = !fifo_empty || last_vld;
  assign out_rsp   = fifo_empty ? last_rsp : fifo_head;
  assign rsp_hs    = rsp_valid && bus.rsp_ready;
  assign fifo_push = last_vld && !(fifo_empty && bus.rsp_ready);
  assign fifo_pop  = rsp_hs && !fifo_empty;

  mem_rsp_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (last_rsp),
    .pop       (fifo_pop),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rsp_valid ? out_rsp.rdata : '0;
  assign bus.rsp_err   = rsp_valid ? out_rsp.err   : 1'b0;

endmodule

// File: doc/memory_pipe.md
Name: memory_pipe

Overview:
- Parametrised single-port synchronous RAM and the successor to the flat 2048x16 word memory.
- Adds byte-write enables, a valid/ready request channel and a configurable registered read latency.
- Adds a response buffer with backpressure and out-of-range detection.
- Sits between the core's load/store unit (or instruction fetch) and the storage array.
- Lets the memory map to block RAM and tolerate a stalled consumer without losing read data.

Parameters:
- ADDR_WIDTH, 11: word-address width.
- DATA_WIDTH, 16: word width. Must be a multiple of 8.
- DEPTH, 2**ADDR_WIDTH: number of implemented words. Must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH.
- READ_LATENCY, 1: cycles from read acceptance to earliest rsp_valid. Legal range 1..4.
- RSP_DEPTH, 2: response FIFO entries. Must be >= 1. Full throughput needs RSP_DEPTH >= READ_LATENCY+1.
- BE_WIDTH, DATA_WIDTH/8: byte-enable width. Derived; never overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- req_be  in  BE_WIDTH  byte enables; bit i covers wdata[8i+7:8i].
- rsp_valid  out  1  read response available.
- rsp_ready  in  1  consumer takes the response when rsp_valid && rsp_ready.
- rsp_rdata  out  DATA_WIDTH  read data.
- rsp_err  out  1  the read address was >= DEPTH.

Behaviour:
- Reset values: req_ready=0 while rst_n=0, and 1 from the first cycle after release. rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Reset clears pipeline valids, the FIFO pointers and the outstanding counter. The array contents are not reset.
- Reset mid-operation: in-flight reads and buffered responses are dropped silently. No response follows reset release.
- Outstanding count: credits = in-flight reads + FIFO occupancy.
  - +1 on read accept only.
  - -1 on response handshake.
  - Both in the same cycle: unchanged.
- req_ready = (credits < RSP_DEPTH). It is a function of registered state only, never of req_valid or req_we. Writes are gated identically.
- Write accepted in cycle N: the array updates at the edge ending cycle N, for enabled bytes only.
  - req_be=0: no-op, but the write is still accepted.
  - Address >= DEPTH: write is ignored. No response and no error output.
- Read accepted in cycle N:
  - The array is sampled at the edge ending cycle N (stage 1).
  - READ_LATENCY-1 further register stages follow.
  - The result enters the first-word-fall-through FIFO.
  - rsp_valid is asserted in cycle N+READ_LATENCY if the FIFO was empty.
- Out-of-range read: rdata=0, err=1. It travels the same pipeline and the same latency as a normal read.
- Ordering: responses are returned in acceptance order.
  - A read accepted in cycle N+1 after a write to the same address in cycle N returns the new data.
  - The single request port makes same-cycle read/write collisions impossible.
- Backpressure: while rsp_ready=0, responses accumulate in the FIFO.
  - Credits guarantee the FIFO never overflows and no pipeline stall is needed.
  - rsp_rdata and rsp_err hold stable while rsp_valid && !rsp_ready.
- Simultaneous FIFO push and pop when full: impossible by credit rule. When empty with FIFO fall-through, the push appears next cycle.
- Unimplemented BE bits do not apply, because DATA_WIDTH is a multiple of 8.
- Illegal parameters are caught by an elaboration-time check.

Decomposition:
- Package memory_pkg holds:
  - the READ_LATENCY bounds (MIN 1, MAX 4);
  - the byte width constant 8;
  - the response struct type {rdata, err}, parameterised via localparam widths.
- One natural sub-module: mem_rsp_fifo.
  - Synchronous FIFO with first-word fall-through.
  - Parameters WIDTH=DATA_WIDTH+1 and DEPTH=RSP_DEPTH.
  - Asynchronous active-low reset on pointers and count only.
- The credit counter, array and latency pipeline stay in memory_pipe.

Test Plan:
- Defaults, rsp_ready=1: write addr 0x005, data 0xBEEF, be=11, then read 0x005 next cycle -> rsp_valid exactly 1 cycle after read accept, rdata=0xBEEF, err=0.
- Byte enables: write 0x010 data 0x1234 be=11, then write 0x010 data 0xAB00 be=10, then read -> 0xAB34.
- READ_LATENCY=3, RSP_DEPTH=4, rsp_ready=1: read addresses 0..7 back-to-back -> req_ready stays 1, responses arrive in order at 3-cycle latency with one per cycle.
- Backpressure, defaults: hold rsp_ready=0 and issue reads -> exactly 2 accepted, then req_ready=0. Release rsp_ready -> both responses delivered in order and stable while stalled, after which req_ready returns to 1.
- DEPTH=1000: read 0x3F0 -> rdata=0, err=1. Write 0x3F0 then read 0x000 -> location 0 unchanged.
- Reset mid-operation: assert rst_n=0 with 2 responses buffered -> rsp_valid=0 immediately. After release, req_ready=1 and no stale response appears. Data written before reset is still read back.
